sgd_err_gen: RTL and testbench

SGD_ERR_GEN -- requirements
Module: sgd_err_gen

---
 rtl/sgd_err_gen_if.sv | 29 ++
 rtl/sgd_err_gen.sv | 176 +++++++++++++++++
 tb/tb_sgd_err_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sgd_err_gen_if.sv
// sgd_err_gen_if: bundle of the sample-chunk stream, label/start control and
// the scaled-error output handshake of the SGD error generator.
// master = stimulus / upstream + downstream side, slave = sgd_err_gen.
interface sgd_err_gen_if #(
  parameter int INPUT_BITWIDTH = 8,
  parameter int BITWIDTH       = 16,
  parameter int SIZE           = 10
);
  logic                             start;
  logic signed [BITWIDTH-1:0]       y;
  logic                             x_valid;
  logic                             x_ready;
  logic [INPUT_BITWIDTH*SIZE-1:0]   x;
  logic [BITWIDTH*SIZE-1:0]         w;
  logic                             grad_valid;
  logic                             grad_ready;
  logic [BITWIDTH*SIZE-1:0]         grad;
  logic                             busy;

  modport master (
    output start, y, x_valid, x, w, grad_ready,
    input  x_ready, grad_valid, grad, busy
  );

  modport slave (
    input  start, y, x_valid, x, w, grad_ready,
    output x_ready, grad_valid, grad, busy
  );
endinterface

// File: rtl/sgd_err_gen.sv
// sgd_err_gen: streams NUM_CHUNKS chunks of SIZE sample/weight lanes, forms
// the dot product x.w, subtracts the latched label y, scales the error by
// 2^-LR_SHIFT (arithmetic shift) and presents it replicated on every lane of
// grad for the downstream SGD update stage.
// Optional feature: define SGD_ERR_SAT_EN to saturate the scaled error to the
// signed BITWIDTH range; otherwise it wraps (low BITWIDTH bits kept).
module sgd_err_gen #(
  parameter int INPUT_BITWIDTH = 8,
  parameter int BITWIDTH       = 16,
  parameter int SIZE           = 10,
  parameter int NUM_CHUNKS     = 4,
  parameter int LR_SHIFT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  sgd_err_gen_if.slave      bus
);

  localparam int PROD_W = INPUT_BITWIDTH + BITWIDTH;
  localparam int ACC_W  = BITWIDTH + INPUT_BITWIDTH + $clog2(SIZE * NUM_CHUNKS);
  localparam int CNT_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ACC, ERR, OUT} state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      x_ready_r;
  logic                      grad_valid_r;
  logic                      busy_r;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          cnt;
  logic signed [BITWIDTH-1:0] y_r;
  logic signed [BITWIDTH-1:0] e_r;
  logic signed [PROD_W-1:0]  prod [SIZE];
  logic signed [ACC_W-1:0]   chunk_sum;
  logic signed [ACC_W:0]     diff;
  logic signed [ACC_W:0]     shifted;
  logic signed [BITWIDTH-1:0] e_next;
  logic                      hs;

`ifdef SGD_ERR_SAT_EN
  localparam logic signed [ACC_W:0] E_MAX =
    {{(ACC_W + 2 - BITWIDTH){1'b0}}, {(BITWIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] E_MIN =
    {{(ACC_W + 2 - BITWIDTH){1'b1}}, {(BITWIDTH - 1){1'b0}}};

  // Clamp a wide signed error into the signed BITWIDTH range.
  function automatic logic signed [BITWIDTH-1:0] sat_err(input logic signed [ACC_W:0] v);
    logic signed [BITWIDTH-1:0] r;
    if (v > E_MAX) begin
      r = E_MAX[BITWIDTH-1:0];
    end else if (v < E_MIN) begin
      r = E_MIN[BITWIDTH-1:0];
    end else begin
      r = v[BITWIDTH-1:0];
    end
    return r;
  endfunction
`endif

  // A chunk is consumed only while ACC advertises ready.
  assign hs = bus.x_valid && x_ready_r;

  // Per-lane signed products of the current chunk.
  for (genvar i = 0; i < SIZE; i++) begin : g_prod
    assign prod[i] = $signed(bus.x[INPUT_BITWIDTH*i +: INPUT_BITWIDTH])
                   * $signed(bus.w[BITWIDTH*i +: BITWIDTH]);
  end

  // Sign-extended sum of all lane products of the current chunk.
  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < SIZE; i++) begin
      chunk_sum = chunk_sum + ACC_W'(prod[i]);
    end
  end

  // Scaled error: (acc - y) >>> LR_SHIFT, then reduced to BITWIDTH.
  always_comb begin
    diff    = (ACC_W + 1)'(acc) - (ACC_W + 1)'(y_r);
    shifted = diff >>> LR_SHIFT;
`ifdef SGD_ERR_SAT_EN
    e_next  = sat_err(shifted);
`else
    e_next  = shifted[BITWIDTH-1:0];
`endif
  end

  // FSM state register and registered status outputs derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      x_ready_r    <= 1'b0;
      grad_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state        <= state_next;
      x_ready_r    <= (state_next == ACC);
      grad_valid_r <= (state_next == OUT);
      busy_r       <= (state_next != IDLE);
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ACC;
        end else begin
          state_next = IDLE;
        end
      end
      ACC: begin
        if (hs && (cnt == LAST_CHUNK)) begin
          state_next = ERR;
        end else begin
          state_next = ACC;
        end
      end
      ERR: begin
        state_next = OUT;
      end
      OUT: begin
        if (grad_valid_r && bus.grad_ready) begin
          state_next = IDLE;
        end else begin
          state_next = OUT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: label latch, accumulator, chunk counter and error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      y_r <= '0;
      e_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            y_r <= bus.y;
            acc <= '0;
            cnt <= '0;
          end
        end
        ACC: begin
          if (hs) begin
            acc <= acc + chunk_sum;
            cnt <= (cnt == LAST_CHUNK) ? '0 : cnt + 1'b1;
          end
        end
        ERR: begin
          e_r <= e_next;
        end
        default: begin
          e_r <= e_r;
        end
      endcase
    end
  end

  assign bus.x_ready    = x_ready_r;
  assign bus.grad_valid = grad_valid_r;
  assign bus.busy       = busy_r;
  assign bus.grad       = {SIZE{e_r}};

endmodule

// File: tb/tb_sgd_err_gen.sv
// tb_sgd_err_gen: directed scoreboard bench for sgd_err_gen (SIZE=10,
// NUM_CHUNKS=4, LR_SHIFT=4, BITWIDTH=16). Stimulus pushes the hand-computed
// lane value into a queue; a monitor pops and compares on every accepted
// grad handshake.
module tb_sgd_err_gen;
  localparam int IBW  = 8;
  localparam int BW   = 16;
  localparam int SZ   = 10;
  localparam int NCH  = 4;

`ifdef SGD_ERR_SAT_EN
  localparam logic [BW-1:0] BIG_EXP = 16'h7FFF;
`else
  localparam logic [BW-1:0] BIG_EXP = 16'hBEC2;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [BW-1:0] exp_q[$];

  sgd_err_gen_if #(.INPUT_BITWIDTH(IBW), .BITWIDTH(BW), .SIZE(SZ)) bus ();

  sgd_err_gen #(
    .INPUT_BITWIDTH(IBW), .BITWIDTH(BW), .SIZE(SZ),
    .NUM_CHUNKS(NCH), .LR_SHIFT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted grad is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.grad_valid && bus.grad_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got grad lane %0h expected nothing", bus.grad[BW-1:0]);
      end else begin
        logic [BW-1:0] e;
        e = exp_q.pop_front();
        if (bus.grad !== {SZ{e}}) begin
          errors++;
          $display("FAIL sb_grad: got %0h expected all lanes %0h", bus.grad, e);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_x_ready"},    {31'd0, bus.x_ready},    32'd0);
    check({tag, "_grad_valid"}, {31'd0, bus.grad_valid}, 32'd0);
    check({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
    checks++;
    if (bus.grad !== '0) begin
      errors++;
      $display("FAIL %s_grad: got %0h expected 0", tag, bus.grad);
    end
  endtask

  // Pulse start with label (called #1 after a rising edge).
  task automatic start_sample(input logic [BW-1:0] ye);
    bus.start = 1'b1;
    bus.y     = ye;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.y     = '0;
  endtask

  // Wait (bounded) for a chunk handshake; returns #1 after that edge.
  task automatic wait_hs();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.x_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout: got no x_ready expected handshake");
    end
  endtask

  task automatic send_chunks(input logic [IBW-1:0] xe, input logic [BW-1:0] we,
                             input int n, input int gap);
    for (int c = 0; c < n; c++) begin
      for (int g = 0; g < gap; g++) begin
        bus.x_valid = 1'b0;
        @(posedge clk); #1;
      end
      for (int i = 0; i < SZ; i++) begin
        bus.x[IBW*i +: IBW] = xe;
        bus.w[BW*i +: BW]   = we;
      end
      bus.x_valid = 1'b1;
      wait_hs();
    end
    bus.x_valid = 1'b0;
  endtask

  // Full sample: grad_valid low in ERR, high at the 2nd edge after the last handshake.
  task automatic full_sample(input logic [IBW-1:0] xe, input logic [BW-1:0] we,
                             input logic [BW-1:0] ye, input logic [BW-1:0] e,
                             input int gap);
    exp_q.push_back(e);
    start_sample(ye);
    check("busy_acc", {31'd0, bus.busy}, 32'd1);
    send_chunks(xe, we, NCH, gap);
    check("valid_err", {31'd0, bus.grad_valid}, 32'd0);
    check("xready_err", {31'd0, bus.x_ready}, 32'd0);
    @(posedge clk); #1;
    check("valid_lat", {31'd0, bus.grad_valid}, 32'd1);
    if (bus.grad_ready) begin
      @(posedge clk); #1;
      check("idle_after", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.y          = '0;
    bus.x_valid    = 1'b0;
    bus.x          = '0;
    bus.w          = '0;
    bus.grad_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // all x=1, w=2, y=16: acc=80, (80-16)>>>4 = 4
    full_sample(8'd1, 16'd2, 16'd16, 16'd4, 0);
    // all x=-1, w=3, y=8: acc=-120, (-128)>>>4 = -8
    full_sample(8'hFF, 16'd3, 16'd8, 16'hFFF8, 0);
    // all x=127, w=32767, y=0: acc=166456360, >>>4 = 10403522 -> sat or wrap
    full_sample(8'd127, 16'd32767, 16'd0, BIG_EXP, 0);

    // Output stall with start pulsed while in OUT
    bus.grad_ready = 1'b0;
    full_sample(8'd1, 16'd2, 16'd16, 16'd4, 0);
    for (int k = 0; k < 5; k++) begin
      bus.start = 1'b1;
      check("stall_valid", {31'd0, bus.grad_valid}, 32'd1);
      checks++;
      if (bus.grad !== {SZ{16'd4}}) begin
        errors++;
        $display("FAIL stall_grad: got %0h expected all lanes 4", bus.grad);
      end
      @(posedge clk); #1;
    end
    bus.start      = 1'b0;
    bus.grad_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_idle", {31'd0, bus.busy}, 32'd0);
    check("stall_valid_drop", {31'd0, bus.grad_valid}, 32'd0);

    // Reset mid-ACC after two chunks, then a clean sample
    start_sample(16'd16);
    send_chunks(8'd1, 16'd2, 2, 0);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    full_sample(8'd1, 16'd2, 16'd16, 16'd4, 0);

    // Three idle cycles before every chunk
    full_sample(8'd1, 16'd2, 16'd16, 16'd4, 3);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
